// File: rtl/port_req_arbiter.sv
// -----------------------------------------------------------------------------
// port_req_arbiter
//
// Purpose:
//   Per-output round-robin arbiter placed in front of the shared-memory mux
//   controller. Every input port presents a beat (valid, destination, last).
//   Each output port grants at most one input per cycle. An output stays locked
//   to its owner from the first beat of a packet until the last beat, so
//   multi-beat packets are never interleaved. The registered grant matrix
//   (port_vaild) lags the handshake by one cycle. That lag lines it up with the
//   data register that the input stage loads on the handshake.
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   in_valid    [PORT_NUB]            input j has a beat available
//   in_dest     [PORT_NUB*WIDTH_SEL]  destination of input j, slice j*WIDTH_SEL
//   in_last     [PORT_NUB]            beat of input j ends its packet
//   full_in     [PORT_NUB]            output o cannot accept a beat this cycle
//   in_ready    [PORT_NUB]            beat of input j is accepted this cycle
//   port_vaild  [PORT_NUB*PORT_NUB]   registered grants, bit j*PORT_NUB+o
// -----------------------------------------------------------------------------
module port_req_arbiter #(
  parameter  int PORT_NUB  = 4,
  localparam int WIDTH_SEL = (PORT_NUB > 1) ? $clog2(PORT_NUB) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORT_NUB-1:0]           in_valid,
  input  logic [PORT_NUB*WIDTH_SEL-1:0] in_dest,
  input  logic [PORT_NUB-1:0]           in_last,
  input  logic [PORT_NUB-1:0]           full_in,
  output logic [PORT_NUB-1:0]           in_ready,
  output logic [PORT_NUB*PORT_NUB-1:0]  port_vaild
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  arb_state_e           state_q [PORT_NUB];
  arb_state_e           state_d [PORT_NUB];
  logic [WIDTH_SEL-1:0] owner_q [PORT_NUB];
  logic [WIDTH_SEL-1:0] owner_d [PORT_NUB];
  logic [WIDTH_SEL-1:0] rr_q    [PORT_NUB];
  logic [WIDTH_SEL-1:0] rr_d    [PORT_NUB];

  logic [PORT_NUB-1:0]          busy;
  logic [PORT_NUB-1:0]          cand  [PORT_NUB];
  logic [PORT_NUB-1:0]          grant [PORT_NUB];
  logic [PORT_NUB-1:0]          pv_col [PORT_NUB];
  logic [PORT_NUB*PORT_NUB-1:0] grant_flat;

  // Round-robin pick: returns a one-hot vector selecting the first request at
  // or after ptr, wrapping modulo PORT_NUB. Returns zero when nothing requests.
  function automatic logic [PORT_NUB-1:0] rr_pick(
    input logic [PORT_NUB-1:0]  req,
    input logic [WIDTH_SEL-1:0] ptr
  );
    logic [PORT_NUB-1:0] onehot;
    logic                done;
    int                  idx;
    onehot = '0;
    done   = 1'b0;
    for (int k = 0; k < PORT_NUB; k++) begin
      idx = (int'(ptr) + k) % PORT_NUB;
      if (!done && req[idx]) begin
        onehot[idx] = 1'b1;
        done        = 1'b1;
      end
    end
    return onehot;
  endfunction

  // An input that owns a locked output is committed to that packet. It must
  // not be picked up by a second output even if its in_dest changes.
  always_comb begin
    busy = '0;
    for (int o = 0; o < PORT_NUB; o++) begin
      if (state_q[o] == LOCKED) begin
        busy[owner_q[o]] = 1'b1;
      end
    end
  end

  // Candidate sets and grants per output. A locked output only listens to its
  // owner and ignores in_dest. An idle output takes any free input that is
  // addressed to it. Destinations >= PORT_NUB never match any output index.
  always_comb begin
    for (int o = 0; o < PORT_NUB; o++) begin
      cand[o]  = '0;
      grant[o] = '0;
      if (state_q[o] == LOCKED) begin
        cand[o][owner_q[o]] = in_valid[owner_q[o]];
      end else begin
        for (int j = 0; j < PORT_NUB; j++) begin
          cand[o][j] = in_valid[j] && !busy[j] &&
                       (int'(in_dest[j*WIDTH_SEL +: WIDTH_SEL]) == o);
        end
      end
      if (!full_in[o] && !rst) begin
        grant[o] = rr_pick(cand[o], rr_q[o]);
      end
    end
  end

  // Fold the per-output grants into the per-input ready vector and into the
  // input-major flat matrix that port_vaild registers.
  always_comb begin
    in_ready   = '0;
    grant_flat = '0;
    for (int o = 0; o < PORT_NUB; o++) begin
      pv_col[o] = '0;
      for (int j = 0; j < PORT_NUB; j++) begin
        in_ready[j]               = in_ready[j] | grant[o][j];
        grant_flat[j*PORT_NUB+o]  = grant[o][j];
        pv_col[o][j]              = port_vaild[j*PORT_NUB+o];
      end
    end
  end

  // Next-state logic. A granted beat always transfers, because a grant
  // requires in_valid. The last beat releases the lock and moves the pointer
  // past the winner. A non-last beat on an idle output opens a lock.
  always_comb begin
    for (int o = 0; o < PORT_NUB; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      rr_d[o]    = rr_q[o];
      for (int j = 0; j < PORT_NUB; j++) begin
        if (grant[o][j]) begin
          if (in_last[j]) begin
            state_d[o] = IDLE;
            rr_d[o]    = WIDTH_SEL'((j + 1) % PORT_NUB);
          end else if (state_q[o] == IDLE) begin
            state_d[o] = LOCKED;
            owner_d[o] = WIDTH_SEL'(j);
          end
        end
      end
    end
  end

  // State registers and the registered grant matrix.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < PORT_NUB; o++) begin
        state_q[o] <= IDLE;
        owner_q[o] <= '0;
        rr_q[o]    <= '0;
      end
      port_vaild <= '0;
    end else begin
      for (int o = 0; o < PORT_NUB; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        rr_q[o]    <= rr_d[o];
      end
      port_vaild <= grant_flat;
    end
  end

  // Each output column of both the live grant and the registered matrix must
  // be zero or one-hot. Otherwise the downstream mux would merge two inputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int o = 0; o < PORT_NUB; o++) begin
        assert ($onehot0(grant[o]));
        assert ($onehot0(pv_col[o]));
      end
    end
  end

endmodule

// File: tb/tb_port_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_port_req_arbiter
//
// Purpose:
//   Self-checking bench for port_req_arbiter. The stimulus process drives one
//   cycle of inputs at a time. For each cycle it asks a behavioural model
//   (per output: current owner or none, plus a next-preferred index) which
//   input each output serves. It then queues the expected in_ready for that
//   cycle and the expected port_vaild for the following cycle. An independent
//   monitor samples the DUT after every falling edge and checks it against
//   the queued expectations.
// -----------------------------------------------------------------------------
module tb_port_req_arbiter;

  localparam int N = 4;
  localparam int W = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_dest;
  logic [N-1:0]   in_last;
  logic [N-1:0]   full_in;
  logic [N-1:0]   in_ready;
  logic [N*N-1:0] port_vaild;

  int tests_run = 0;
  int tests_failed = 0;

  logic [N-1:0]   exp_ready_q [$];
  logic [N*N-1:0] exp_pv_q    [$];

  // Model state: m_owner[o] is the input that holds output o mid-packet, or -1
  // when the output is free. m_ptr[o] is the first index scanned when free.
  int m_owner [N];
  int m_ptr   [N];

  port_req_arbiter #(.PORT_NUB(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_dest    (in_dest),
    .in_last    (in_last),
    .full_in    (full_in),
    .in_ready   (in_ready),
    .port_vaild (port_vaild)
  );

  always #5 clk = ~clk;

  // Pack four destinations (input 0 first) into the in_dest bus layout.
  function automatic logic [N*W-1:0] dests(input int d0, input int d1,
                                           input int d2, input int d3);
    logic [N*W-1:0] d;
    d = {W'(d3), W'(d2), W'(d1), W'(d0)};
    return d;
  endfunction

  // Drive one cycle of inputs and queue what the model says must happen.
  task automatic applyStimulus(input logic r, input logic [N-1:0] v,
                               input logic [N*W-1:0] d, input logic [N-1:0] l,
                               input logic [N-1:0] f);
    logic [N-1:0]   e_ready;
    logic [N*N-1:0] e_pv;
    bit             busy [N];
    int             winner [N];
    int             j;
    @(negedge clk);
    rst      = r;
    in_valid = v;
    in_dest  = d;
    in_last  = l;
    full_in  = f;
    e_ready  = '0;
    e_pv     = '0;
    if (r) begin
      for (int o = 0; o < N; o++) begin
        m_owner[o] = -1;
        m_ptr[o]   = 0;
      end
    end else begin
      for (int k = 0; k < N; k++) busy[k] = 1'b0;
      for (int o = 0; o < N; o++) if (m_owner[o] >= 0) busy[m_owner[o]] = 1'b1;
      for (int o = 0; o < N; o++) begin
        winner[o] = -1;
        if (f[o]) continue;
        if (m_owner[o] >= 0) begin
          if (v[m_owner[o]]) winner[o] = m_owner[o];
        end else begin
          for (int k = 0; k < N; k++) begin
            j = (m_ptr[o] + k) % N;
            if (winner[o] < 0 && v[j] && !busy[j] && int'(d[j*W +: W]) == o)
              winner[o] = j;
          end
        end
      end
      for (int o = 0; o < N; o++) begin
        if (winner[o] >= 0) begin
          j = winner[o];
          e_ready[j]   = 1'b1;
          e_pv[j*N+o]  = 1'b1;
          if (l[j]) begin
            m_owner[o] = -1;
            m_ptr[o]   = (j + 1) % N;
          end else begin
            m_owner[o] = j;
          end
        end
      end
    end
    exp_ready_q.push_back(e_ready);
    exp_pv_q.push_back(e_pv);
  endtask

  task automatic checkOutput(input string name, input logic [N*N-1:0] got,
                             input logic [N*N-1:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, got, want);
    end
  endtask

  // Monitor: samples 1 time unit after each falling edge. It checks in_ready
  // for the cycle just driven. It checks port_vaild against the grant queued
  // for the previous cycle.
  initial begin : monitor
    logic [N*N-1:0] pending;
    logic [N-1:0]   er;
    bit             have;
    have    = 1'b0;
    pending = '0;
    forever begin
      @(negedge clk);
      #1;
      if (have) checkOutput("port_vaild", port_vaild, pending);
      if (exp_ready_q.size() > 0) begin
        er      = exp_ready_q.pop_front();
        pending = exp_pv_q.pop_front();
        have    = 1'b1;
        checkOutput("in_ready", {{(N*N-N){1'b0}}, in_ready}, {{(N*N-N){1'b0}}, er});
      end else begin
        have = 1'b0;
      end
    end
  end

  initial begin : stimulus
    logic [N-1:0]   rv, rl, rf;
    logic [N*W-1:0] rd;
    logic           rr;
    rst      = 1'b1;
    in_valid = '0;
    in_dest  = '0;
    in_last  = '0;
    full_in  = '0;
    for (int o = 0; o < N; o++) begin
      m_owner[o] = -1;
      m_ptr[o]   = 0;
    end

    // Reset with every input valid, then release reset.
    applyStimulus(1'b1, 4'b1111, dests(0, 1, 0, 2), 4'b1111, 4'b0000);
    applyStimulus(1'b1, 4'b1111, dests(0, 1, 0, 2), 4'b1111, 4'b0000);
    applyStimulus(1'b0, 4'b1111, dests(0, 1, 0, 2), 4'b1111, 4'b0000);
    applyStimulus(1'b0, 4'b0000, dests(0, 0, 0, 0), 4'b0000, 4'b0000);

    // Single beat: input 2 to output 1.
    applyStimulus(1'b0, 4'b0100, dests(0, 0, 1, 0), 4'b0100, 4'b0000);
    applyStimulus(1'b0, 4'b0000, dests(0, 0, 0, 0), 4'b0000, 4'b0000);
    applyStimulus(1'b0, 4'b0000, dests(0, 0, 0, 0), 4'b0000, 4'b0000);

    // Contention on output 2 from inputs 0, 1 and 3.
    repeat (4) applyStimulus(1'b0, 4'b1011, dests(2, 2, 2, 2), 4'b1111, 4'b0000);
    applyStimulus(1'b0, 4'b0000, dests(0, 0, 0, 0), 4'b0000, 4'b0000);

    // Multi-beat lock: input 1 sends three beats to output 0 while input 0 waits.
    applyStimulus(1'b0, 4'b0010, dests(0, 0, 0, 0), 4'b0000, 4'b0000);
    applyStimulus(1'b0, 4'b0011, dests(0, 0, 0, 0), 4'b0000, 4'b0000);
    applyStimulus(1'b0, 4'b0011, dests(0, 0, 0, 0), 4'b0011, 4'b0000);
    applyStimulus(1'b0, 4'b0001, dests(0, 0, 0, 0), 4'b0001, 4'b0000);
    applyStimulus(1'b0, 4'b0000, dests(0, 0, 0, 0), 4'b0000, 4'b0000);

    // Backpressure on output 3 while input 0 is mid-packet and input 2 waits.
    applyStimulus(1'b0, 4'b0001, dests(3, 0, 3, 0), 4'b0000, 4'b0000);
    repeat (3) applyStimulus(1'b0, 4'b0101, dests(3, 0, 3, 0), 4'b0000, 4'b1000);
    applyStimulus(1'b0, 4'b0101, dests(3, 0, 3, 0), 4'b0001, 4'b0000);
    applyStimulus(1'b0, 4'b0100, dests(3, 0, 3, 0), 4'b0100, 4'b0000);
    applyStimulus(1'b0, 4'b0000, dests(0, 0, 0, 0), 4'b0000, 4'b0000);

    // Parallel permutation, then a four-beat variant cut short by reset.
    applyStimulus(1'b0, 4'b1111, dests(3, 2, 1, 0), 4'b1111, 4'b0000);
    applyStimulus(1'b0, 4'b0000, dests(0, 0, 0, 0), 4'b0000, 4'b0000);
    applyStimulus(1'b0, 4'b1111, dests(3, 2, 1, 0), 4'b0000, 4'b0000);
    applyStimulus(1'b0, 4'b1111, dests(3, 2, 1, 0), 4'b0000, 4'b0000);
    applyStimulus(1'b1, 4'b1111, dests(3, 2, 1, 0), 4'b0000, 4'b0000);
    applyStimulus(1'b0, 4'b1111, dests(0, 0, 0, 0), 4'b1111, 4'b0000);
    applyStimulus(1'b0, 4'b1111, dests(1, 1, 2, 2), 4'b1111, 4'b0000);
    applyStimulus(1'b0, 4'b0000, dests(0, 0, 0, 0), 4'b0000, 4'b0000);

    // Randomised traffic with occasional backpressure and resets.
    for (int c = 0; c < 2000; c++) begin
      rv = N'($urandom);
      rd = (N*W)'($urandom);
      rl = N'($urandom & $urandom);
      rf = N'($urandom & $urandom & $urandom);
      rr = ($urandom_range(0, 199) == 0);
      applyStimulus(rr, rv, rd, rl, rf);
    end

    applyStimulus(1'b0, 4'b0000, dests(0, 0, 0, 0), 4'b0000, 4'b0000);
    repeat (2) @(negedge clk);
    #3;
    if (exp_ready_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_ready_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
